alu_issue: RTL and testbench
============================

ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 clk  input  1  rising-edge clock for all state.
REQ-002 rst  input  1  reset, synchronous, active-high.
REQ-003 instr_valid  input  1  instruction word offered.
REQ-004 instr  input  32  MIPS word: opcode[31:26], rs[25:21], rt[20:16], rd[15:11], funct[5:0], imm[15:0].
REQ-005 instr_ready  output  1  block accepts instr this cycle.
REQ-006 alu_opcode  output  6  opcode driven to ALU.
REQ-007 alu_funct  output  6  funct driven to ALU.
REQ-008 alu_busA  output  32  first ALU operand.
REQ-009 alu_busB  output  32  second ALU operand.
REQ-010 alu_result  input  32  combinational ALU result.
REQ-011 alu_zero  input  1  ALU zero flag, sampled into zero_flag.
REQ-012 wb_valid  output  1  one-cycle pulse: writeback performed.
REQ-013 wb_reg  output  5  destination register of current writeback.
REQ-014 wb_data  output  32  data of current writeback.
REQ-015 illegal  output  1  one-cycle pulse: instruction rejected.
REQ-016 zero_flag  output  1  alu_zero captured at last writeback.
REQ-017 dbg_addr  input  5 / dbg_data  output  32  combinational register-file read port.

Function
REQ-018 FSM states IDLE, ISSUE, WB; handshake completes when instr_valid and instr_ready both high on a rising edge.
REQ-019 instr_ready SHALL be 1 only in IDLE; IDLE->ISSUE on handshake, instr latched; instr_valid without ready is ignored.
REQ-020 Legal set: opcode 6'h00 with funct ADD 6'h20, SUB 6'h22, MUL 6'h18, DIV 6'h1A; opcode ADDI 6'h08; all else illegal.
REQ-021 ISSUE: drive alu_opcode/alu_funct from latched instr, alu_busA=R[rs], alu_busB=R[rt] (R-type) or sign-extended imm16 (ADDI); ISSUE->WB next cycle.
REQ-022 Outside ISSUE, alu_opcode=6'h3F, alu_funct=0, alu_busA=alu_busB=0 (ALU idles as NOP).
REQ-023 WB: write alu_result (sampled at end of ISSUE) to R[rd] (R-type) or R[rt] (ADDI); wb_valid=1 for exactly that cycle; WB->IDLE.
REQ-024 Latency: handshake at edge N -> wb_valid high in cycle N+2; next handshake no earlier than edge N+3.
REQ-025 R[0] SHALL read 0 always; write to register 0 still pulses wb_valid with wb_reg=0 but does not change R[0].
REQ-026 Illegal instruction: illegal pulses one cycle in ISSUE, no ALU drive, no writeback, ISSUE->IDLE.
REQ-027 Arithmetic is 32-bit modulo; MUL keeps low 32 bits; DIV unsigned; overflow never flagged.
REQ-028 dbg_data reflects a write on the cycle after the WB edge.

Reset
REQ-029 On rst: state=IDLE, all 32 registers=0, wb_valid=0, wb_reg=0, wb_data=0, illegal=0, zero_flag=0, instr_ready=1 the cycle after rst deasserts.
REQ-030 rst in ISSUE or WB SHALL abort the instruction with no register write and no wb_valid pulse.

Configuration
REQ-031 Macro ALU_ISSUE_DIV0_TRAP_EN defined: DIV with R[rt]==0 pulses illegal, no writeback; undefined: DIV with R[rt]==0 writes 32'hFFFFFFFF without using alu_result, wb_valid pulses.

Structure
REQ-032 Opcode/funct constants, NOP drive value 6'h3F and FSM state encoding reside in the shared opcode include/package.
REQ-033 Register file (2 combinational read ports plus dbg, 1 sync write, R0 hardwired) is sub-module alu_issue_regfile.

Verification
REQ-034 Reset, ADDI r1,r0,5 -> wb_valid at N+2, wb_reg=1, wb_data=5; dbg_addr=1 -> 5.
REQ-035 ADDI r2,r0,-3 then SUB r3,r1,r2 -> wb_data 32'hFFFFFFFD then 8; MUL r4,r1,r1 -> 25.
REQ-036 ADDI r0,r0,7 -> wb_valid, wb_reg=0; dbg_addr=0 -> 0.
REQ-037 opcode 0 funct 6'h3F -> illegal pulse, no wb_valid, registers unchanged; DIV r5,r1,r0 -> trap or 32'hFFFFFFFF per macro.
REQ-038 rst asserted during ISSUE of ADD r6,r1,r1 -> no wb_valid, dbg r1=0, instr_ready=1 after deassert.

Source files
------------

// File: rtl/alu_issue_pkg.sv
// Shared opcode/funct constants, ALU NOP drive value and FSM encoding for alu_issue.
package alu_issue_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_NOP   = 6'h3F;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_MUL = 6'h18;
  localparam logic [5:0] FN_DIV = 6'h1A;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WB    = 2'd2
  } state_t;

  typedef struct packed {
    logic [5:0] opcode;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [4:0] shamt;
    logic [5:0] funct;
  } instr_t;

  function automatic logic is_legal(instr_t i);
    logic rtype_ok;
    rtype_ok = (i.funct == FN_ADD) || (i.funct == FN_SUB) ||
               (i.funct == FN_MUL) || (i.funct == FN_DIV);
    return (i.opcode == OP_ADDI) || ((i.opcode == OP_RTYPE) && rtype_ok);
  endfunction

  function automatic logic [31:0] imm_sext(instr_t i);
    logic [15:0] imm;
    imm = {i.rd, i.shamt, i.funct};
    return {{16{imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/alu_issue_regfile.sv
// 32x32 register file: two combinational operand reads, a debug read, one synchronous write.
// R0 is never written and resets to zero, so it always reads zero.
module alu_issue_regfile
  import alu_issue_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ra_addr,
  output logic [31:0] ra_data,
  input  logic [4:0]  rb_addr,
  output logic [31:0] rb_data,
  input  logic [4:0]  dbg_addr,
  output logic [31:0] dbg_data,
  input  logic        wr_en,
  input  logic [4:0]  wr_addr,
  input  logic [31:0] wr_data
);

  logic [31:0] regs_q [32];
  logic [31:0] regs_d [32];

  always_comb begin
    regs_d = regs_q;
    if (wr_en && (wr_addr != 5'd0)) begin
      regs_d[wr_addr] = wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      regs_q <= '{default: '0};
    end else begin
      regs_q <= regs_d;
    end
  end

  assign ra_data  = regs_q[ra_addr];
  assign rb_data  = regs_q[rb_addr];
  assign dbg_data = regs_q[dbg_addr];

endmodule

// File: rtl/alu_issue.sv
// Single-issue ALU sequencer (IDLE->ISSUE->WB); handshake at edge N gives wb_valid in cycle N+2,
// instr_ready only in IDLE. ALU_ISSUE_DIV0_TRAP_EN turns DIV-by-zero into an illegal trap.
module alu_issue
  import alu_issue_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  input  logic [31:0] instr,
  output logic        instr_ready,
  output logic [5:0]  alu_opcode,
  output logic [5:0]  alu_funct,
  output logic [31:0] alu_busA,
  output logic [31:0] alu_busB,
  input  logic [31:0] alu_result,
  input  logic        alu_zero,
  output logic        wb_valid,
  output logic [4:0]  wb_reg,
  output logic [31:0] wb_data,
  output logic        illegal,
  output logic        zero_flag,
  input  logic [4:0]  dbg_addr,
  output logic [31:0] dbg_data
);

  state_t      state_q, state_d;
  logic [5:0]  alu_opcode_q, alu_opcode_d;
  logic [5:0]  alu_funct_q, alu_funct_d;
  logic [31:0] alu_busA_q, alu_busA_d;
  logic [31:0] alu_busB_q, alu_busB_d;
  logic        illegal_q, illegal_d;
  logic        wb_valid_q, wb_valid_d;
  logic [4:0]  wb_reg_q, wb_reg_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        zero_flag_q, zero_flag_d;
  logic [4:0]  dest_q, dest_d;
  logic        div0_q, div0_d;

  instr_t      in_w;
  logic [31:0] ra_data, rb_data;

  assign in_w = instr_t'(instr);

  // Operands are read in IDLE straight off the offered word; nothing writes the file in IDLE.
  alu_issue_regfile u_regfile (
    .clk      (clk),
    .rst      (rst),
    .ra_addr  (in_w.rs),
    .ra_data  (ra_data),
    .rb_addr  (in_w.rt),
    .rb_data  (rb_data),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data),
    .wr_en    (state_q == ST_WB),
    .wr_addr  (wb_reg_q),
    .wr_data  (wb_data_q)
  );

  always_comb begin
    logic is_addi, div_by_zero, bad;
    is_addi      = (in_w.opcode == OP_ADDI);
    div_by_zero  = (in_w.opcode == OP_RTYPE) && (in_w.funct == FN_DIV) && (rb_data == 32'd0);
    bad          = 1'b0;
    state_d      = state_q;
    alu_opcode_d = OP_NOP;
    alu_funct_d  = 6'd0;
    alu_busA_d   = 32'd0;
    alu_busB_d   = 32'd0;
    illegal_d    = 1'b0;
    wb_valid_d   = 1'b0;
    wb_reg_d     = wb_reg_q;
    wb_data_d    = wb_data_q;
    zero_flag_d  = zero_flag_q;
    dest_d       = dest_q;
    div0_d       = div0_q;

    case (state_q)
      ST_IDLE: begin
        if (instr_valid) begin
          state_d = ST_ISSUE;
`ifdef ALU_ISSUE_DIV0_TRAP_EN
          bad    = !is_legal(in_w) || div_by_zero;
          div0_d = 1'b0;
`else
          bad    = !is_legal(in_w);
          div0_d = div_by_zero;
`endif
          illegal_d = bad;
          dest_d    = is_addi ? in_w.rt : in_w.rd;
          if (!bad) begin
            alu_opcode_d = in_w.opcode;
            alu_funct_d  = in_w.funct;
            alu_busA_d   = ra_data;
            alu_busB_d   = is_addi ? imm_sext(in_w) : rb_data;
          end
        end
      end
      ST_ISSUE: begin
        if (illegal_q) begin
          state_d = ST_IDLE;
        end else begin
          state_d     = ST_WB;
          wb_valid_d  = 1'b1;
          wb_reg_d    = dest_q;
          wb_data_d   = div0_q ? 32'hFFFF_FFFF : alu_result;
          zero_flag_d = alu_zero;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      alu_opcode_q <= OP_NOP;
      alu_funct_q  <= 6'd0;
      alu_busA_q   <= 32'd0;
      alu_busB_q   <= 32'd0;
      illegal_q    <= 1'b0;
      wb_valid_q   <= 1'b0;
      wb_reg_q     <= 5'd0;
      wb_data_q    <= 32'd0;
      zero_flag_q  <= 1'b0;
      dest_q       <= 5'd0;
      div0_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      alu_opcode_q <= alu_opcode_d;
      alu_funct_q  <= alu_funct_d;
      alu_busA_q   <= alu_busA_d;
      alu_busB_q   <= alu_busB_d;
      illegal_q    <= illegal_d;
      wb_valid_q   <= wb_valid_d;
      wb_reg_q     <= wb_reg_d;
      wb_data_q    <= wb_data_d;
      zero_flag_q  <= zero_flag_d;
      dest_q       <= dest_d;
      div0_q       <= div0_d;
    end
  end

  assign instr_ready = (state_q == ST_IDLE);
  assign alu_opcode  = alu_opcode_q;
  assign alu_funct   = alu_funct_q;
  assign alu_busA    = alu_busA_q;
  assign alu_busB    = alu_busB_q;
  assign illegal     = illegal_q;
  // A reset landing in WB squashes the pulse; the register file clears in the same edge.
  assign wb_valid    = wb_valid_q & ~rst;
  assign wb_reg      = wb_reg_q;
  assign wb_data     = wb_data_q;
  assign zero_flag   = zero_flag_q;

endmodule

// File: tb/tb_alu_issue.sv
// Directed vector bench for alu_issue with a behavioural ALU on the alu_* port pair.
module tb_alu_issue;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic [31:0] instr;
  logic        instr_ready;
  logic [5:0]  alu_opcode;
  logic [5:0]  alu_funct;
  logic [31:0] alu_busA;
  logic [31:0] alu_busB;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic        wb_valid;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        illegal;
  logic        zero_flag;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  alu_issue dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_ready (instr_ready),
    .alu_opcode  (alu_opcode),
    .alu_funct   (alu_funct),
    .alu_busA    (alu_busA),
    .alu_busB    (alu_busB),
    .alu_result  (alu_result),
    .alu_zero    (alu_zero),
    .wb_valid    (wb_valid),
    .wb_reg      (wb_reg),
    .wb_data     (wb_data),
    .illegal     (illegal),
    .zero_flag   (zero_flag),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data)
  );

  // External ALU: DIV by zero returns a marker value the sequencer must not forward.
  always_comb begin
    alu_result = 32'd0;
    if (alu_opcode == 6'h08) begin
      alu_result = alu_busA + alu_busB;
    end else if (alu_opcode == 6'h00) begin
      case (alu_funct)
        6'h20: alu_result = alu_busA + alu_busB;
        6'h22: alu_result = alu_busA - alu_busB;
        6'h18: alu_result = alu_busA * alu_busB;
        6'h1A: alu_result = (alu_busB == 32'd0) ? 32'hDEAD_BEEF : alu_busA / alu_busB;
        default: alu_result = 32'd0;
      endcase
    end
    alu_zero = (alu_result == 32'd0);
  end

  typedef struct {
    logic [31:0] ins;
    logic        exp_ill;
    logic        exp_wb;
    logic [4:0]  exp_reg;
    logic [31:0] exp_data;
    logic        exp_zero;
    logic [4:0]  dbg_a;
    logic [31:0] exp_dbg;
  } vec_t;

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Entered and left just after a falling edge; ISSUE, WB and the following IDLE are each sampled.
  task automatic apply(input vec_t v, input int idx);
    chk($sformatf("v%0d ready", idx), {31'd0, instr_ready}, 32'd1);
    instr_valid = 1'b1;
    instr       = v.ins;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    chk($sformatf("v%0d issue illegal", idx), {31'd0, illegal}, {31'd0, v.exp_ill});
    chk($sformatf("v%0d issue opcode", idx), {26'd0, alu_opcode},
        v.exp_ill ? 32'h3F : {26'd0, v.ins[31:26]});
    chk($sformatf("v%0d issue ready", idx), {31'd0, instr_ready}, 32'd0);
    @(negedge clk);
    chk($sformatf("v%0d wb_valid", idx), {31'd0, wb_valid}, {31'd0, v.exp_wb});
    chk($sformatf("v%0d illegal cleared", idx), {31'd0, illegal}, 32'd0);
    if (v.exp_wb) begin
      chk($sformatf("v%0d wb_reg", idx), {27'd0, wb_reg}, {27'd0, v.exp_reg});
      chk($sformatf("v%0d wb_data", idx), wb_data, v.exp_data);
    end
    @(negedge clk);
    dbg_addr = v.dbg_a;
    #1;
    chk($sformatf("v%0d dbg r%0d", idx, v.dbg_a), dbg_data, v.exp_dbg);
    chk($sformatf("v%0d zero_flag", idx), {31'd0, zero_flag}, {31'd0, v.exp_zero});
  endtask

  vec_t vecs[14];
  vec_t v_rst;

  initial begin
    rst         = 1'b1;
    instr_valid = 1'b0;
    instr       = 32'd0;
    dbg_addr    = 5'd0;

    //      ins                                 ill   wb    reg   data            zf    dbg   dbg value
    vecs[0]  = '{itype(6'h08, 0, 1, 16'd5),      1'b0, 1'b1, 5'd1, 32'd5,          1'b0, 5'd1, 32'd5};
    vecs[1]  = '{itype(6'h08, 0, 2, 16'hFFFD),   1'b0, 1'b1, 5'd2, 32'hFFFF_FFFD,  1'b0, 5'd2, 32'hFFFF_FFFD};
    vecs[2]  = '{rtype(1, 2, 3, 6'h22),          1'b0, 1'b1, 5'd3, 32'd8,          1'b0, 5'd3, 32'd8};
    vecs[3]  = '{rtype(1, 1, 4, 6'h18),          1'b0, 1'b1, 5'd4, 32'd25,         1'b0, 5'd4, 32'd25};
    vecs[4]  = '{itype(6'h08, 0, 0, 16'd7),      1'b0, 1'b1, 5'd0, 32'd7,          1'b0, 5'd0, 32'd0};
    vecs[5]  = '{rtype(1, 2, 9, 6'h3F),          1'b1, 1'b0, 5'd0, 32'd0,          1'b0, 5'd9, 32'd0};
    vecs[6]  = '{rtype(1, 2, 6, 6'h20),          1'b0, 1'b1, 5'd6, 32'd2,          1'b0, 5'd6, 32'd2};
    vecs[7]  = '{rtype(4, 1, 7, 6'h1A),          1'b0, 1'b1, 5'd7, 32'd5,          1'b0, 5'd7, 32'd5};
`ifdef ALU_ISSUE_DIV0_TRAP_EN
    vecs[8]  = '{rtype(1, 0, 5, 6'h1A),          1'b1, 1'b0, 5'd0, 32'd0,          1'b0, 5'd5, 32'd0};
`else
    vecs[8]  = '{rtype(1, 0, 5, 6'h1A),          1'b0, 1'b1, 5'd5, 32'hFFFF_FFFF,  1'b0, 5'd5, 32'hFFFF_FFFF};
`endif
    vecs[9]  = '{itype(6'h23, 1, 10, 16'd4),     1'b1, 1'b0, 5'd0, 32'd0,          1'b0, 5'd10, 32'd0};
    vecs[10] = '{itype(6'h08, 2, 8, 16'h8000),   1'b0, 1'b1, 5'd8, 32'hFFFF_7FFD,  1'b0, 5'd8, 32'hFFFF_7FFD};
    vecs[11] = '{rtype(2, 1, 9, 6'h1A),          1'b0, 1'b1, 5'd9, 32'h3333_3332,  1'b0, 5'd9, 32'h3333_3332};
    vecs[12] = '{rtype(1, 1, 10, 6'h22),         1'b0, 1'b1, 5'd10, 32'd0,         1'b1, 5'd10, 32'd0};
    vecs[13] = '{itype(6'h08, 0, 11, 16'd1),     1'b0, 1'b1, 5'd11, 32'd1,         1'b0, 5'd1, 32'd5};

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset instr_ready", {31'd0, instr_ready}, 32'd1);
    chk("reset wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("reset wb_reg", {27'd0, wb_reg}, 32'd0);
    chk("reset wb_data", wb_data, 32'd0);
    chk("reset illegal", {31'd0, illegal}, 32'd0);
    chk("reset zero_flag", {31'd0, zero_flag}, 32'd0);
    chk("reset alu_opcode", {26'd0, alu_opcode}, 32'h3F);
    chk("reset alu_busA", alu_busA, 32'd0);

    for (int i = 0; i < 14; i++) begin
      apply(vecs[i], i);
    end

    // Reset arriving mid-ISSUE of ADD r6,r1,r1 must squash the writeback.
    instr_valid = 1'b1;
    instr       = rtype(1, 1, 6, 6'h20);
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    chk("abort in issue", {26'd0, alu_opcode}, 32'h00);
    rst = 1'b1;
    @(negedge clk);
    chk("abort wb_valid", {31'd0, wb_valid}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("abort wb_valid after", {31'd0, wb_valid}, 32'd0);
    chk("abort instr_ready", {31'd0, instr_ready}, 32'd1);
    dbg_addr = 5'd1;
    #1;
    chk("abort dbg r1", dbg_data, 32'd0);
    dbg_addr = 5'd6;
    #1;
    chk("abort dbg r6", dbg_data, 32'd0);

    // The file works again after the abort.
    v_rst = '{itype(6'h08, 0, 1, 16'd9), 1'b0, 1'b1, 5'd1, 32'd9, 1'b0, 5'd1, 32'd9};
    apply(v_rst, 99);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
